// File: rtl/bcd_datetime_counter.sv
// BCD time-of-day and Gregorian calendar counter with prescaled second tick
// and a six-field edit FSM (next_field / inc / dec).
module bcd_datetime_counter #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          FAST_DIV = 500,
  parameter logic [15:0] RST_YEAR = 16'h2024,
  parameter int          PRE_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast,
  input  logic        next_field,
  input  logic        inc,
  input  logic        dec,
  output logic [23:0] time_bcd,
  output logic [31:0] date_bcd,
  output logic [2:0]  field_sel,
  output logic        sec_tick,
  output logic        day_rollover
);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_SEC  = 3'd1,
    S_MIN  = 3'd2,
    S_HOUR = 3'd3,
    S_DAY  = 3'd4,
    S_MON  = 3'd5,
    S_YEAR = 3'd6
  } state_t;

  state_t           r_state;
  logic [7:0]       r_sec, r_min, r_hour, r_day, r_mon;
  logic [15:0]      r_year;
  logic [PRE_W-1:0] r_pre;
  logic             r_sec_tick, r_day_rollover;

  // Two-digit BCD step with wrap; >= / <= keep an out-of-range value recoverable.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v >= hi)              return lo;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v <= lo)              return hi;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return v - 8'd1;
  endfunction

  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
        else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (b) begin
        if (r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
        else begin
          r[4*k +: 4] = r[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A two-digit BCD number is divisible by 4 iff (even tens, units 0/4/8) or (odd tens, units 2/6).
  function automatic logic div4_bcd(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    if (y[7:0] != 8'h00) return div4_bcd(y[7:0]);
    else                 return div4_bcd(y[15:8]);
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] m, input logic [15:0] y);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [PRE_W-1:0] w_div_m1;
  logic             w_tick, w_edit_inc, w_edit_dec;
  logic [7:0]       w_dim_cur, w_mon_new;
  logic [15:0]      w_year_new;
  state_t           w_state_next;

  assign w_div_m1   = fast ? PRE_W'(FAST_DIV - 1) : PRE_W'(CLK_HZ - 1);
  assign w_tick     = (r_state == S_RUN) && (r_pre >= w_div_m1);
  assign w_edit_inc = inc & ~dec & ~next_field;
  assign w_edit_dec = dec & ~inc & ~next_field;
  assign w_dim_cur  = dim(r_mon, r_year);
  assign w_mon_new  = w_edit_inc ? bcd2_inc(r_mon, 8'h01, 8'h12) : bcd2_dec(r_mon, 8'h01, 8'h12);
  assign w_year_new = w_edit_inc ? bcd4_inc(r_year) : bcd4_dec(r_year);

  always_comb begin
    case (r_state)
      S_RUN:   w_state_next = S_SEC;
      S_SEC:   w_state_next = S_MIN;
      S_MIN:   w_state_next = S_HOUR;
      S_HOUR:  w_state_next = S_DAY;
      S_DAY:   w_state_next = S_MON;
      S_MON:   w_state_next = S_YEAR;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_sec          <= 8'h00;
      r_min          <= 8'h00;
      r_hour         <= 8'h00;
      r_day          <= 8'h01;
      r_mon          <= 8'h01;
      r_year         <= RST_YEAR;
      r_pre          <= '0;
      r_sec_tick     <= 1'b0;
      r_day_rollover <= 1'b0;
    end else begin
      r_sec_tick     <= w_tick;
      r_day_rollover <= 1'b0;
      // Prescaler only runs while in RUN; leaving or re-entering RUN restarts it.
      if (r_state == S_RUN && !next_field) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      else                                 r_pre <= '0;

      if (w_tick) begin
        r_sec <= bcd2_inc(r_sec, 8'h00, 8'h59);
        if (r_sec == 8'h59) begin
          r_min <= bcd2_inc(r_min, 8'h00, 8'h59);
          if (r_min == 8'h59) begin
            r_hour <= bcd2_inc(r_hour, 8'h00, 8'h23);
            if (r_hour == 8'h23) begin
              r_day_rollover <= 1'b1;
              if (r_day >= w_dim_cur) begin
                r_day <= 8'h01;
                r_mon <= bcd2_inc(r_mon, 8'h01, 8'h12);
                if (r_mon == 8'h12) r_year <= bcd4_inc(r_year);
              end else begin
                r_day <= bcd2_inc(r_day, 8'h01, w_dim_cur);
              end
            end
          end
        end
      end

      if (next_field) begin
        r_state <= w_state_next;
      end else if (w_edit_inc || w_edit_dec) begin
        case (r_state)
          S_SEC:  r_sec  <= w_edit_inc ? bcd2_inc(r_sec, 8'h00, 8'h59) : bcd2_dec(r_sec, 8'h00, 8'h59);
          S_MIN:  r_min  <= w_edit_inc ? bcd2_inc(r_min, 8'h00, 8'h59) : bcd2_dec(r_min, 8'h00, 8'h59);
          S_HOUR: r_hour <= w_edit_inc ? bcd2_inc(r_hour, 8'h00, 8'h23) : bcd2_dec(r_hour, 8'h00, 8'h23);
          S_DAY:  r_day  <= w_edit_inc ? bcd2_inc(r_day, 8'h01, w_dim_cur) : bcd2_dec(r_day, 8'h01, w_dim_cur);
          S_MON: begin
            r_mon <= w_mon_new;
            r_day <= min8(r_day, dim(w_mon_new, r_year));
          end
          S_YEAR: begin
            r_year <= w_year_new;
            r_day  <= min8(r_day, dim(r_mon, w_year_new));
          end
          default: ;
        endcase
      end
    end
  end

  assign time_bcd     = {r_hour, r_min, r_sec};
  assign date_bcd     = {r_day, r_mon, r_year};
  assign field_sel    = r_state;
  assign sec_tick     = r_sec_tick;
  assign day_rollover = r_day_rollover;

endmodule

// File: tb/tb_bcd_datetime_counter.sv
// Directed bench for bcd_datetime_counter: edit fields to preset dates, then
// check rollover, leap years, clamping, input priority and reset.
module tb_bcd_datetime_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fast = 1'b0;
  logic        next_field = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic [23:0] time_bcd;
  logic [31:0] date_bcd;
  logic [2:0]  field_sel;
  logic        sec_tick;
  logic        day_rollover;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  bcd_datetime_counter #(
    .CLK_HZ(10), .FAST_DIV(2), .RST_YEAR(16'h2024), .PRE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .fast(fast), .next_field(next_field), .inc(inc), .dec(dec),
    .time_bcd(time_bcd), .date_bcd(date_bcd), .field_sel(field_sel),
    .sec_tick(sec_tick), .day_rollover(day_rollover)
  );

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected nothing", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
    $display("check %-18s observed %h expected %h", t, obs, e);
  endtask

  task automatic cyc(input logic nf, input logic i, input logic d);
    next_field = nf; inc = i; dec = d;
    @(posedge clk); #1;
    next_field = 1'b0; inc = 1'b0; dec = 1'b0;
  endtask

  task automatic press(input int n, input logic nf, input logic i, input logic d);
    repeat (n) cyc(nf, i, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Time is always preset to 23:59:59; date adjusted from 01-01-2024, then RUN with fast=1.
  task automatic preload(input int day_inc, input int day_dec, input int mon_inc, input int mon_dec,
                         input int yr_inc, input int yr_dec);
    do_reset();
    fast = 1'b0;
    cyc(1, 0, 0); cyc(0, 0, 1);
    cyc(1, 0, 0); cyc(0, 0, 1);
    cyc(1, 0, 0); cyc(0, 0, 1);
    cyc(1, 0, 0); press(day_inc, 0, 1, 0); press(day_dec, 0, 0, 1);
    cyc(1, 0, 0); press(mon_inc, 0, 1, 0); press(mon_dec, 0, 0, 1);
    cyc(1, 0, 0); press(yr_inc, 0, 1, 0); press(yr_dec, 0, 0, 1);
    fast = 1'b1;
    cyc(1, 0, 0);
  endtask

  task automatic run_tick(input string name, input logic [31:0] exp_date);
    int n;
    expect_val({name, "_tick_seen"}, 64'd1);
    expect_val({name, "_time"}, 64'h000000);
    expect_val({name, "_date"}, {32'd0, exp_date});
    expect_val({name, "_rollover"}, 64'd1);
    expect_val({name, "_rollover_end"}, 64'd0);
    n = 0;
    while (sec_tick !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({63'd0, sec_tick});
    check({40'd0, time_bcd});
    check({32'd0, date_bcd});
    check({63'd0, day_rollover});
    @(posedge clk); #1;
    check({62'd0, day_rollover, sec_tick});
  endtask

  initial begin
    // Reset state
    do_reset();
    expect_val("rst_field", 64'd0);
    expect_val("rst_time", 64'h000000);
    expect_val("rst_date", 64'h01012024);
    expect_val("rst_tick", 64'd0);
    check({61'd0, field_sel});
    check({40'd0, time_bcd});
    check({32'd0, date_bcd});
    check({63'd0, sec_tick});

    // Year-end rollover
    preload(0, 1, 0, 1, 0, 0);
    run_tick("ye2024", 32'h0101_2025);

    // Leap-year cases on 28-02
    preload(27, 0, 1, 0, 0, 0);
    run_tick("leap2024", 32'h2902_2024);
    preload(27, 0, 1, 0, 76, 0);
    run_tick("leap2100", 32'h0103_2100);
    preload(27, 0, 1, 0, 0, 24);
    run_tick("leap2000", 32'h2902_2000);
    preload(27, 0, 1, 0, 0, 1);
    run_tick("leap2023", 32'h0103_2023);

    // Year 9999 wrap while running
    preload(0, 1, 0, 1, 0, 2025);
    run_tick("ye9999", 32'h0101_0000);

    // Year edit wrap in YEAR state
    do_reset();
    press(6, 1, 0, 0);
    press(2025, 0, 0, 1);
    expect_val("yr_edit_9999", 64'h01019999);
    check({32'd0, date_bcd});
    cyc(0, 1, 0);
    expect_val("yr_edit_wrap", 64'h01010000);
    check({32'd0, date_bcd});

    // Month edit clamps day: 31-01-2023
    do_reset();
    fast = 1'b0;
    press(4, 1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    expect_val("clamp_preset", 64'h31012023);
    check({32'd0, date_bcd});
    press(5, 1, 0, 0);
    expect_val("clamp_field_mon", 64'd5);
    check({61'd0, field_sel});
    cyc(0, 1, 0);
    expect_val("clamp_mon_inc", 64'h28022023);
    check({32'd0, date_bcd});
    cyc(0, 0, 1);
    expect_val("clamp_mon_dec", 64'h28012023);
    check({32'd0, date_bcd});

    // SEC editing and input priority
    do_reset();
    cyc(1, 0, 0);
    expect_val("sec_field", 64'd1);
    check({61'd0, field_sel});
    cyc(0, 0, 1);
    expect_val("sec_dec_wrap", 64'h000059);
    check({40'd0, time_bcd});
    cyc(0, 1, 1);
    expect_val("sec_incdec", 64'h000059);
    check({40'd0, time_bcd});
    cyc(1, 1, 0);
    expect_val("nf_wins_field", 64'd2);
    expect_val("nf_wins_time", 64'h000059);
    check({61'd0, field_sel});
    check({40'd0, time_bcd});

    // Reset during HOUR edit with fast=1
    do_reset();
    fast = 1'b1;
    press(3, 1, 0, 0);
    expect_val("hour_field", 64'd3);
    check({61'd0, field_sel});
    do_reset();
    expect_val("mid_rst_field", 64'd0);
    expect_val("mid_rst_time", 64'h000000);
    expect_val("mid_rst_date", 64'h01012024);
    expect_val("mid_rst_tick", 64'd0);
    check({61'd0, field_sel});
    check({40'd0, time_bcd});
    check({32'd0, date_bcd});
    check({63'd0, sec_tick});
    @(posedge clk); #1;
    expect_val("post_rst_no_tick", 64'd0);
    check({63'd0, sec_tick});
    @(posedge clk); #1;
    expect_val("post_rst_tick", 64'd1);
    expect_val("post_rst_time", 64'h000001);
    check({63'd0, sec_tick});
    check({40'd0, time_bcd});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
